// File: rtl/cms_pix28_package.sv
// Shared constants and types for the CMS pix28 command/status path.
// Holds the test numbering and the testx status encoder state/error codes.
package cms_pix28_package;

  localparam logic [3:0] test_number_1 = 4'd1;
  localparam logic [3:0] test_number_2 = 4'd2;
  localparam logic [3:0] test_number_3 = 4'd3;
  localparam logic [3:0] test_number_4 = 4'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } testx_status_state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_TEST      = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
  localparam logic [1:0] ERR_COLLISION = 2'd3;

  // Maps a one-hot start vector (bit k-1 = test k) to its test number.
  function automatic logic [3:0] start_to_test_number(input logic [3:0] start);
    logic [3:0] num;
    num = 4'd0;
    case (start)
      4'b0001: num = test_number_1;
      4'b0010: num = test_number_2;
      4'b0100: num = test_number_3;
      4'b1000: num = test_number_4;
      default: num = 4'd0;
    endcase
    return num;
  endfunction

endpackage

// File: rtl/com_testx_watchdog.sv
// Saturating elapsed-cycle counter for one test run, with a timeout flag
// that fires on the last allowed cycle (TIMEOUT_CYCLES = 0 disables it).
module com_testx_watchdog #(
  parameter int                CNT_W          = 24,
  parameter logic [CNT_W-1:0]  TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             timeout_hit
);

  localparam logic [CNT_W-1:0] LAST_CYCLE = TIMEOUT_CYCLES - CNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES == '0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      assign timeout_hit = (count == LAST_CYCLE);
    end
  endgenerate

endmodule

// File: rtl/com_testx_status_encoder.sv
// Tracks one active test from the start/done/error strobes of the test
// engines and encodes the outcome into a sticky, fully registered status word.
module com_testx_status_encoder
  import cms_pix28_package::*;
#(
  parameter int                CNT_W          = 24,
  parameter logic [CNT_W-1:0]  TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_code_w_reset,
  input  logic             status_clear,
  input  logic [3:0]       test_start,
  input  logic [3:0]       test_done,
  input  logic [3:0]       test_error,
  output logic             status_busy,
  output logic             status_done,
  output logic [1:0]       status_err_code,
  output logic [3:0]       status_test_number,
  output logic [CNT_W-1:0] status_cycles,
  output logic             status_end_pulse
);

  testx_status_state_t state;
  logic [3:0]          active_mask;
  logic                any_start;
  logic                hit_error;
  logic                hit_done;
  logic                timeout_hit;
  logic                wd_clear;
  logic                wd_enable;

  assign any_start = |test_start;
  assign hit_error = |(test_error & active_mask);
  assign hit_done  = |(test_done & active_mask);
  assign wd_clear  = op_code_w_reset || ((state != RUN) && any_start);
  assign wd_enable = (state == RUN);

  com_testx_watchdog #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (wd_clear),
    .enable      (wd_enable),
    .count       (status_cycles),
    .timeout_hit (timeout_hit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= IDLE;
      active_mask        <= '0;
      status_busy        <= 1'b0;
      status_done        <= 1'b0;
      status_err_code    <= ERR_NONE;
      status_test_number <= '0;
      status_end_pulse   <= 1'b0;
    end else if (op_code_w_reset) begin
      state              <= IDLE;
      active_mask        <= '0;
      status_busy        <= 1'b0;
      status_done        <= 1'b0;
      status_err_code    <= ERR_NONE;
      status_test_number <= '0;
      status_end_pulse   <= 1'b0;
    end else begin
      status_end_pulse <= 1'b0;
      if (state == RUN) begin
        // Collision beats error, error beats done, done beats timeout.
        if (any_start) begin
          state            <= ERROR;
          status_busy      <= 1'b0;
          status_err_code  <= ERR_COLLISION;
          status_end_pulse <= 1'b1;
        end else if (hit_error) begin
          state            <= ERROR;
          status_busy      <= 1'b0;
          status_err_code  <= ERR_TEST;
          status_end_pulse <= 1'b1;
        end else if (hit_done) begin
          state            <= DONE;
          status_busy      <= 1'b0;
          status_done      <= 1'b1;
          status_end_pulse <= 1'b1;
        end else if (timeout_hit) begin
          state            <= ERROR;
          status_busy      <= 1'b0;
          status_err_code  <= ERR_TIMEOUT;
          status_end_pulse <= 1'b1;
        end
      end else if (any_start) begin
        // IDLE, DONE and ERROR all accept a new start; it outranks status_clear.
        status_done <= 1'b0;
        if ($onehot(test_start)) begin
          state              <= RUN;
          active_mask        <= test_start;
          status_busy        <= 1'b1;
          status_err_code    <= ERR_NONE;
          status_test_number <= start_to_test_number(test_start);
        end else begin
          state              <= ERROR;
          active_mask        <= '0;
          status_busy        <= 1'b0;
          status_err_code    <= ERR_COLLISION;
          status_test_number <= '0;
          status_end_pulse   <= 1'b1;
        end
      end else if ((state != IDLE) && status_clear) begin
        state              <= IDLE;
        active_mask        <= '0;
        status_done        <= 1'b0;
        status_err_code    <= ERR_NONE;
        status_test_number <= '0;
      end
    end
  end

endmodule

// File: tb/tb_com_testx_status_encoder.sv
// Directed self-checking bench for com_testx_status_encoder with a short
// watchdog limit so the timeout paths are reachable quickly.
module tb_com_testx_status_encoder;

  localparam int               CNT_W   = 24;
  localparam logic [CNT_W-1:0] TIMEOUT = 24'd100;

  logic             clk = 1'b0;
  logic             resetn;
  logic             op_code_w_reset;
  logic             status_clear;
  logic [3:0]       test_start;
  logic [3:0]       test_done;
  logic [3:0]       test_error;
  logic             status_busy;
  logic             status_done;
  logic [1:0]       status_err_code;
  logic [3:0]       status_test_number;
  logic [CNT_W-1:0] status_cycles;
  logic             status_end_pulse;

  int tests = 0;
  int fails = 0;
  int busy_cnt;

  com_testx_status_encoder #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .op_code_w_reset    (op_code_w_reset),
    .status_clear       (status_clear),
    .test_start         (test_start),
    .test_done          (test_done),
    .test_error         (test_error),
    .status_busy        (status_busy),
    .status_done        (status_done),
    .status_err_code    (status_err_code),
    .status_test_number (status_test_number),
    .status_cycles      (status_cycles),
    .status_end_pulse   (status_end_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic check_all(input string tag, input logic busy, input logic done,
                           input logic [1:0] err, input logic [3:0] tn,
                           input logic [CNT_W-1:0] cyc, input logic endp);
    check({tag, ".busy"}, 32'(status_busy), 32'(busy));
    check({tag, ".done"}, 32'(status_done), 32'(done));
    check({tag, ".err"},  32'(status_err_code), 32'(err));
    check({tag, ".tn"},   32'(status_test_number), 32'(tn));
    check({tag, ".cyc"},  32'(status_cycles), 32'(cyc));
    check({tag, ".endp"}, 32'(status_end_pulse), 32'(endp));
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes_off();
    test_start   = 4'b0000;
    test_done    = 4'b0000;
    test_error   = 4'b0000;
    status_clear = 1'b0;
    op_code_w_reset = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL bench_timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    resetn = 1'b0;
    strobes_off();
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 2'd0, 4'd0, '0, 1'b0);
    #2 resetn = 1'b1;
    tick();

    // Clean run of test 2 with a foreign done/error strobe in the middle.
    test_start = 4'b0010;
    tick();
    strobes_off();
    check_all("run2_start", 1'b1, 1'b0, 2'd0, 4'd2, 24'd0, 1'b0);
    busy_cnt = 1;
    for (int i = 1; i < 50; i++) begin
      if (i == 10) begin
        test_done  = 4'b1000;
        test_error = 4'b1000;
      end
      tick();
      strobes_off();
      if (status_busy === 1'b1) busy_cnt++;
      if (i == 10) check_all("foreign", 1'b1, 1'b0, 2'd0, 4'd2, 24'd10, 1'b0);
    end
    check("busy_cycles", 32'(busy_cnt), 32'd50);
    test_done = 4'b0010;
    tick();
    strobes_off();
    check_all("run2_done", 1'b0, 1'b1, 2'd0, 4'd2, 24'd50, 1'b1);
    tick();
    check_all("run2_hold", 1'b0, 1'b1, 2'd0, 4'd2, 24'd50, 1'b0);

    // Clear from DONE keeps the cycle count; clear in IDLE does nothing.
    status_clear = 1'b1;
    tick();
    check_all("clear_done", 1'b0, 1'b0, 2'd0, 4'd0, 24'd50, 1'b0);
    tick();
    strobes_off();
    check_all("clear_idle", 1'b0, 1'b0, 2'd0, 4'd0, 24'd50, 1'b0);

    // Error beats done; status_clear mid-run is ignored.
    test_start = 4'b0001;
    tick();
    strobes_off();
    tick();
    status_clear = 1'b1;
    tick();
    strobes_off();
    tick();
    check_all("run1_clear_ignored", 1'b1, 1'b0, 2'd0, 4'd1, 24'd3, 1'b0);
    test_done  = 4'b0001;
    test_error = 4'b0001;
    tick();
    strobes_off();
    check_all("err_beats_done", 1'b0, 1'b0, 2'd1, 4'd1, 24'd4, 1'b1);

    // Multi-bit start from a terminal state behaves as from IDLE.
    test_start = 4'b0101;
    tick();
    strobes_off();
    check("coll_idle.err",  32'(status_err_code), 32'd3);
    check("coll_idle.tn",   32'(status_test_number), 32'd0);
    check("coll_idle.busy", 32'(status_busy), 32'd0);
    check("coll_idle.endp", 32'(status_end_pulse), 32'd1);

    // Start of test 4 while test 1 runs.
    test_start = 4'b0001;
    tick();
    strobes_off();
    check_all("rearm1", 1'b1, 1'b0, 2'd0, 4'd1, 24'd0, 1'b0);
    tick();
    tick();
    test_start = 4'b1000;
    tick();
    strobes_off();
    check_all("coll_run", 1'b0, 1'b0, 2'd3, 4'd1, 24'd3, 1'b1);

    // Timeout: error exactly 100 cycles after entering RUN.
    test_start = 4'b0100;
    tick();
    strobes_off();
    for (int i = 0; i < 99; i++) tick();
    check_all("to_last", 1'b1, 1'b0, 2'd0, 4'd3, 24'd99, 1'b0);
    tick();
    check_all("timeout", 1'b0, 1'b0, 2'd2, 4'd3, 24'd100, 1'b1);

    // Done on the last allowed cycle beats the timeout.
    test_start = 4'b0100;
    tick();
    strobes_off();
    for (int i = 0; i < 99; i++) tick();
    test_done = 4'b0100;
    tick();
    strobes_off();
    check_all("done_at_99", 1'b0, 1'b1, 2'd0, 4'd3, 24'd100, 1'b1);

    // Synchronous reset overrides a same-cycle done.
    test_start = 4'b0010;
    tick();
    strobes_off();
    for (int i = 0; i < 5; i++) tick();
    op_code_w_reset = 1'b1;
    test_done       = 4'b0010;
    tick();
    strobes_off();
    check_all("sync_reset", 1'b0, 1'b0, 2'd0, 4'd0, 24'd0, 1'b0);

    // Asynchronous reset mid-run clears outputs before the next edge.
    test_start = 4'b0010;
    tick();
    strobes_off();
    for (int i = 0; i < 3; i++) tick();
    #2 resetn = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 1'b0, 2'd0, 4'd0, 24'd0, 1'b0);
    #1 resetn = 1'b1;
    tick();

    // From DONE, start and clear together: the start wins.
    test_start = 4'b0001;
    tick();
    strobes_off();
    test_done = 4'b0001;
    tick();
    strobes_off();
    check_all("pre_restart", 1'b0, 1'b1, 2'd0, 4'd1, 24'd1, 1'b1);
    test_start   = 4'b0001;
    status_clear = 1'b1;
    tick();
    strobes_off();
    check_all("start_beats_clear", 1'b1, 1'b0, 2'd0, 4'd1, 24'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/com_testx_status_encoder.md
Name: com_testx_status_encoder

Overview:
- Return path of the test-command decode. It takes per-test start strobes plus done/error strobes from the test engines, tracks one active test, and encodes the result into a compact status word.
- A watchdog counter bounds each run.
- Status is held sticky until software clears it or starts a new test.
- Sits between the test1..test4 engines and the AXI-lite status register block, in the same clock domain as the command decode.

Parameters:
- CNT_W, 24, width of the elapsed-cycle counter and timeout compare.
- TIMEOUT_CYCLES, 24'd10_000_000, watchdog limit in clk cycles; 0 disables the watchdog.

Ports:
- clk  in  1  same clock as the command decoder (S_AXI_ACLK or pl_clk1)
- resetn  in  1  asynchronous active-low reset
- op_code_w_reset  in  1  synchronous clear, highest priority after resetn
- status_clear  in  1  single-cycle pulse; clears sticky status from a terminal state
- test_start  in  4  bit k-1 = testk_enable_re (single-cycle start strobes)
- test_done  in  4  bit k-1 = testk done pulse
- test_error  in  4  bit k-1 = testk error pulse
- status_busy  out  1  high in RUN
- status_done  out  1  sticky, test completed cleanly
- status_err_code  out  2  0 none, 1 test error, 2 timeout, 3 collision
- status_test_number  out  4  package test_number of the active/last test, 0 if none
- status_cycles  out  CNT_W  elapsed cycles of current/last run, saturating
- status_end_pulse  out  1  one-cycle pulse on entry to any terminal state

Behaviour:
- States: IDLE, RUN, DONE, ERROR.
- Reset (resetn low, asynchronous): state IDLE; all outputs 0.
- op_code_w_reset high (synchronous): the next edge forces the same values as reset, overriding every other input that cycle.
- IDLE, exactly one test_start bit set: RUN next cycle.
  - status_test_number = test_number_k; status_cycles = 0; status_busy = 1; status_done = 0; err_code = 0.
- IDLE, more than one start bit set: ERROR, err_code = 3, test_number = 0.
- RUN, per cycle: status_cycles increments, saturating at all-ones.
- RUN, test_error of the active test: ERROR with err_code = 1. Error wins over done in the same cycle.
- RUN, test_done of the active test without error: DONE with status_done = 1.
- RUN, done/error from a non-active test: ignored.
- RUN, any test_start: ERROR with err_code = 3; test_number keeps the active test.
- RUN, watchdog: if TIMEOUT_CYCLES != 0 and status_cycles == TIMEOUT_CYCLES-1 with no done/error that cycle, go to ERROR with err_code = 2.
  - Done arriving in that same cycle wins over timeout.
- On every transition into DONE or ERROR: status_busy drops to 0 and status_end_pulse is high for exactly that one cycle.
- DONE/ERROR: all status held stable; done/error strobes ignored.
- DONE/ERROR, status_clear: IDLE; clears done, err_code, test_number. status_cycles is retained for readout.
- DONE/ERROR, a start strobe: treated exactly as from IDLE, so re-arm needs no clear.
  - A start in the same cycle as status_clear: the start wins.
- status_clear in IDLE or RUN: no effect.
- Latency: status changes appear one cycle after the causing strobe. All outputs are registered.

Decomposition:
- Add to cms_pix28_package:
  - enum testx_status_state_t {IDLE, RUN, DONE, ERROR};
  - constants ERR_NONE = 2'd0, ERR_TEST = 2'd1, ERR_TIMEOUT = 2'd2, ERR_COLLISION = 2'd3;
  - reuse test_number_1..test_number_4.
- One natural sub-module: com_testx_watchdog. It holds the saturating CNT_W counter, with clear/enable inputs and a timeout-hit output compared against TIMEOUT_CYCLES.

Test Plan:
- Clean run: test_start = 4'b0010, 50 cycles later test_done = 4'b0010.
  - Required: busy 1 for 50 cycles; then done = 1, err_code = 0, test_number = test_number_2, status_cycles = 50; one end pulse.
- Error beats done: test_start = 4'b0001, later done and error both = 4'b0001 in the same cycle.
  - Required: err_code = 1, status_done = 0.
- Timeout (TIMEOUT_CYCLES = 100): start test3, no response.
  - Required: ERROR, err_code = 2 exactly 100 cycles after entering RUN.
  - Repeat with done at cycle 99: required DONE.
- Collisions:
  - test_start = 4'b0101 in IDLE: required err_code = 3, test_number = 0.
  - Start test4 during a test1 run: required err_code = 3, test_number = test_number_1.
- Foreign strobe: test_done = 4'b1000 while test2 is running.
  - Required: no change; busy stays 1.
- Reset mid-run:
  - Assert op_code_w_reset during RUN: required all outputs 0 next cycle.
  - Deassert-then-assert resetn asynchronously mid-run: required outputs 0 immediately.
  - Then status_clear + start test1 in the same cycle from DONE: required RUN with test1.
